// File: rtl/seg7_pkg.sv
// Shared types, segment font and encoder for the
// multiplexed seven-segment display driver.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    // gfedcba patterns for the decimal digits
    localparam logic [6:0] SEG_FONT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [7:0] seg_encode(bcd_t d, logic dp);
        logic [6:0] glyph;
        glyph = (d > 4'd9) ? 7'h00 : SEG_FONT[d];
        return {dp, glyph};
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with sanitising
// synchronous load and a wrap pulse.
module bcd_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clkIn,
    input  logic                  resetIn,
    input  logic                  tickIn,
    input  logic                  upIn,
    input  logic                  loadIn,
    input  logic [4*DIGITS-1:0]   loadValueIn,
    output logic [4*DIGITS-1:0]   countOut,
    output logic                  carryOut
);

    logic [4*DIGITS-1:0] count_next;
    logic                carry_next;
    logic                ripple;
    bcd_t                nib;

    always_comb begin
        count_next = countOut;
        carry_next = 1'b0;
        ripple     = 1'b1;
        nib        = '0;
        if (loadIn) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib = loadValueIn[4*i +: 4];
                count_next[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
            end
        end else if (tickIn) begin
            // ripple survives past a digit only while it wraps
            for (int i = 0; i < DIGITS; i++) begin
                nib = countOut[4*i +: 4];
                if (ripple) begin
                    if (upIn) begin
                        if (nib == 4'd9) begin
                            count_next[4*i +: 4] = 4'd0;
                        end else begin
                            count_next[4*i +: 4] = nib + 4'd1;
                            ripple = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            count_next[4*i +: 4] = 4'd9;
                        end else begin
                            count_next[4*i +: 4] = nib - 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
            end
            carry_next = ripple;
        end
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            countOut <= '0;
            carryOut <= 1'b0;
        end else begin
            countOut <= count_next;
            carryOut <= carry_next;
        end
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// N-digit multiplexed 7-segment driver: BCD counter,
// digit scan, PWM brightness, zero blanking, polarity.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int CLK_FREQUENCY    = 27000000,
    parameter int DIGITS           = 4,
    parameter int REFRESH_HZ       = 1000,
    parameter int BRIGHT_BITS      = 4,
    parameter bit DIGIT_ACTIVE_LOW = 1'b0,
    parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
    input  logic                   clkIn,
    input  logic                   resetIn,
    input  logic                   tickIn,
    input  logic                   upIn,
    input  logic                   loadIn,
    input  logic [4*DIGITS-1:0]    loadValueIn,
    input  logic [DIGITS-1:0]      dotIn,
    input  logic [BRIGHT_BITS-1:0] brightnessIn,
    input  logic                   blankZerosIn,
    output logic [4*DIGITS-1:0]    countOut,
    output logic                   carryOut,
    output logic [DIGITS-1:0]      digitEnableOut,
    output logic [7:0]             segmentEnableOut
);

    localparam int SLOT_CYCLES = CLK_FREQUENCY / (REFRESH_HZ * DIGITS);
    localparam int SW = $clog2(SLOT_CYCLES + 1);
    localparam int IW = $clog2(DIGITS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIGIT_OFF = {DIGITS{DIGIT_ACTIVE_LOW}};
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};

    function automatic logic [SW-1:0] on_cycles(
        input logic [BRIGHT_BITS-1:0] b
    );
        if (&b) return SW'(SLOT_CYCLES);
        return SW'((int'(b) * SLOT_CYCLES) >> BRIGHT_BITS);
    endfunction

    logic [SW-1:0]     slot_count;
    logic [SW-1:0]     slot_next;
    logic [IW-1:0]     digit_idx;
    logic [IW-1:0]     idx_next;
    logic [SW-1:0]     on_q;
    logic [SW-1:0]     on_now;
    logic [DIGITS-1:0] enable_next;
    logic [7:0]        seg_next;
    logic              zero_run;
    logic              hide;

    bcd_counter #(.DIGITS(DIGITS)) u_counter (
        .clkIn       (clkIn),
        .resetIn     (resetIn),
        .tickIn      (tickIn),
        .upIn        (upIn),
        .loadIn      (loadIn),
        .loadValueIn (loadValueIn),
        .countOut    (countOut),
        .carryOut    (carryOut)
    );

    always_comb begin
        slot_next = (slot_count == SLOT_LAST) ? '0 : slot_count + 1'b1;
        idx_next  = digit_idx;
        if (slot_count == SLOT_LAST) begin
            idx_next = (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
        end
        // brightness is taken live during the guard cycle, held afterwards
        on_now = (slot_count == '0) ? on_cycles(brightnessIn) : on_q;
        enable_next = '0;
        if (slot_next != '0 && slot_next <= on_now) begin
            enable_next[idx_next] = 1'b1;
        end
    end

    always_comb begin
        zero_run = 1'b1;
        hide     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (countOut[4*i +: 4] == 4'd0);
            if (i == int'(digit_idx)) hide = zero_run && (i != 0);
        end
        seg_next = seg_encode(countOut[4*digit_idx +: 4], dotIn[digit_idx]);
        if (blankZerosIn && hide) seg_next[6:0] = '0;
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            slot_count       <= '0;
            digit_idx        <= '0;
            on_q             <= '0;
            digitEnableOut   <= DIGIT_OFF;
            segmentEnableOut <= SEG_OFF;
        end else begin
            slot_count     <= slot_next;
            digit_idx      <= idx_next;
            digitEnableOut <= enable_next ^ DIGIT_OFF;
            if (slot_count == '0) begin
                on_q             <= on_now;
                segmentEnableOut <= seg_next ^ SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_seg7_scan_counter;

    localparam int K_COUNT  = 0;
    localparam int K_CARRY  = 1;
    localparam int K_DIG    = 2;
    localparam int K_SEG    = 3;
    localparam int K_DIG2   = 4;
    localparam int K_SEG2   = 5;
    localparam int K_COUNT2 = 6;
    localparam int K_CARRY2 = 7;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        string       name;
    } item_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reset2_n;
    logic        tick;
    logic        up;
    logic        load;
    logic [15:0] load_value;
    logic [3:0]  dot;
    logic [3:0]  bright;
    logic        blank;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  dig;
    logic [7:0]  seg;
    logic        idle2 = 1'b0;
    logic [15:0] zero16 = 16'h0;
    logic [3:0]  zero4 = 4'h0;
    logic [3:0]  full4 = 4'hF;
    logic [15:0] count2;
    logic        carry2;
    logic [3:0]  dig2;
    logic [7:0]  seg2;

    int    cyc = 0;
    int    c0 = 0;
    int    compared = 0;
    int    mismatched = 0;
    item_t sb[$];
    item_t it;
    logic [15:0] act;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_counter #(
        .CLK_FREQUENCY(64000), .DIGITS(4), .REFRESH_HZ(1000),
        .BRIGHT_BITS(4), .DIGIT_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
    ) u0 (
        .clkIn(clk), .resetIn(reset_n), .tickIn(tick), .upIn(up),
        .loadIn(load), .loadValueIn(load_value), .dotIn(dot),
        .brightnessIn(bright), .blankZerosIn(blank),
        .countOut(count), .carryOut(carry),
        .digitEnableOut(dig), .segmentEnableOut(seg)
    );

    seg7_scan_counter #(
        .CLK_FREQUENCY(64000), .DIGITS(4), .REFRESH_HZ(1000),
        .BRIGHT_BITS(4), .DIGIT_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u1 (
        .clkIn(clk), .resetIn(reset2_n), .tickIn(idle2), .upIn(idle2),
        .loadIn(idle2), .loadValueIn(zero16), .dotIn(zero4),
        .brightnessIn(full4), .blankZerosIn(idle2),
        .countOut(count2), .carryOut(carry2),
        .digitEnableOut(dig2), .segmentEnableOut(seg2)
    );

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            case (it.kind)
                K_COUNT:  act = count;
                K_CARRY:  act = 16'(carry);
                K_DIG:    act = 16'(dig);
                K_SEG:    act = 16'(seg);
                K_DIG2:   act = 16'(dig2);
                K_SEG2:   act = 16'(seg2);
                K_COUNT2: act = count2;
                default:  act = 16'(carry2);
            endcase
            compared++;
            if (it.cyc != cyc || act !== it.exp) begin
                mismatched++;
                $display("FAIL %s cyc=%0d tag=%0d got=%h want=%h",
                         it.name, cyc, it.cyc, act, it.exp);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_at(input int t, input int kind,
                             input logic [15:0] v, input string nm);
        item_t e;
        e.cyc = t;
        e.kind = kind;
        e.exp = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic op(input logic ld, input logic tk, input logic u,
                      input logic [15:0] v, input logic [15:0] ec,
                      input logic ecc, input string nm);
        load = ld;
        tick = tk;
        up = u;
        load_value = v;
        expect_at(cyc + 1, K_COUNT, ec, nm);
        expect_at(cyc + 1, K_CARRY, 16'(ecc), {nm, "_carry"});
        step();
        load = 1'b0;
        tick = 1'b0;
    endtask

    task automatic align();
        while (((cyc - c0) % 64) != 0) step();
    endtask

    // one display rotation from slot 0 of digit 0
    task automatic rotate(input int on, input logic [7:0] s0,
                          input logic [7:0] s1, input logic [7:0] s2,
                          input logic [7:0] s3, input string nm);
        logic [7:0] segs [4];
        logic [3:0] e;
        int         slot;
        int         d;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int k = 1; k < 64; k++) begin
            slot = k % 16;
            d = k / 16;
            e = (slot != 0 && slot <= on) ? 4'(1 << d) : 4'h0;
            expect_at(cyc + 1, K_DIG, 16'(e), {nm, "_dig"});
            if (slot == 1) expect_at(cyc + 1, K_SEG, 16'(segs[d]), {nm, "_seg"});
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n = 1'b0;
        reset2_n = 1'b0;
        tick = 1'b0;
        up = 1'b0;
        load = 1'b0;
        load_value = '0;
        dot = '0;
        bright = 4'hF;
        blank = 1'b0;
        step();
        step();
        expect_at(cyc + 1, K_COUNT, 16'h0000, "rst_count");
        expect_at(cyc + 1, K_CARRY, 16'h0000, "rst_carry");
        expect_at(cyc + 1, K_DIG, 16'h0000, "rst_dig");
        expect_at(cyc + 1, K_SEG, 16'h0000, "rst_seg");
        expect_at(cyc + 1, K_DIG2, 16'h000F, "rst_dig_low");
        expect_at(cyc + 1, K_SEG2, 16'h00FF, "rst_seg_low");
        expect_at(cyc + 1, K_COUNT2, 16'h0000, "rst_count_low");
        expect_at(cyc + 1, K_CARRY2, 16'h0000, "rst_carry_low");
        step();
        reset_n = 1'b1;
        reset2_n = 1'b1;
        c0 = cyc;
        expect_at(cyc + 1, K_DIG2, 16'h000E, "low_dig0");
        expect_at(cyc + 1, K_SEG2, 16'h00C0, "low_seg0");
        rotate(15, 8'h3F, 8'h3F, 8'h3F, 8'h3F, "startup");

        op(1, 0, 0, 16'h9998, 16'h9998, 0, "load_9998");
        op(0, 1, 1, 16'h0000, 16'h9999, 0, "up_9999");
        op(0, 1, 1, 16'h0000, 16'h0000, 1, "wrap_up");
        op(0, 0, 0, 16'h0000, 16'h0000, 0, "carry_single");
        op(0, 1, 0, 16'h0000, 16'h9999, 1, "wrap_down");
        op(0, 0, 0, 16'h0000, 16'h9999, 0, "idle_hold");
        op(1, 0, 0, 16'h12AF, 16'h1200, 0, "load_sanitize");
        op(1, 1, 1, 16'h9999, 16'h9999, 0, "load_beats_tick");
        op(0, 1, 0, 16'h0000, 16'h9998, 0, "down_plain");
        op(1, 0, 0, 16'h0199, 16'h0199, 0, "load_0199");
        op(0, 1, 1, 16'h0000, 16'h0200, 0, "ripple_up");
        op(0, 1, 0, 16'h0000, 16'h0199, 0, "borrow_down");

        op(1, 0, 0, 16'h0007, 16'h0007, 0, "load_0007");
        blank = 1'b1;
        dot = 4'b0100;
        align();
        rotate(15, 8'h07, 8'h00, 8'h80, 8'h00, "blank");

        blank = 1'b0;
        dot = 4'b0000;
        op(1, 0, 0, 16'h1234, 16'h1234, 0, "load_1234");
        bright = 4'd8;
        align();
        rotate(8, 8'h66, 8'h4F, 8'h5B, 8'h06, "pwm8");

        op(1, 0, 0, 16'h5689, 16'h5689, 0, "load_5689");
        bright = 4'd0;
        align();
        rotate(0, 8'h6F, 8'h7F, 8'h7D, 8'h6D, "pwm0");

        while (((cyc - c0) % 64) != 4) step();
        expect_at(cyc + 1, K_DIG2, 16'h000E, "low_mid_dig");
        expect_at(cyc + 1, K_SEG2, 16'h00C0, "low_mid_seg");
        step();
        expect_at(cyc + 1, K_DIG2, 16'h000F, "async_rst_dig");
        expect_at(cyc + 1, K_SEG2, 16'h00FF, "async_rst_seg");
        @(posedge clk);
        #1 reset2_n = 1'b0;
        @(negedge clk);
        expect_at(cyc + 1, K_DIG2, 16'h000F, "rst_hold_dig");
        step();
        reset2_n = 1'b1;
        expect_at(cyc + 1, K_DIG2, 16'h000E, "rerelease_dig");
        expect_at(cyc + 1, K_SEG2, 16'h00C0, "rerelease_seg");
        step();

        guard = 0;
        while (sb.size() != 0 && guard < 8) begin
            step();
            guard++;
        end
        if (sb.size() != 0) begin
            $display("FAIL sb_drain got=%0d pending want=0", sb.size());
            mismatched += sb.size();
        end
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
